// File: rtl/out_arbiter_if.sv
// Stream bundle between the out_arbiter and its two sources / one sink.
// The master modport is the arbiter's view; slave is the environment's view.
interface out_arbiter_if #(
  parameter int DWIDTH = 128,
  parameter int LEN_W  = 16
);
  logic              en;
  logic [LEN_W-1:0]  burst_len;
  logic [DWIDTH-1:0] s_axis_tdata_0;
  logic              s_axis_tvalid_0;
  logic              s_axis_tready_0;
  logic [DWIDTH-1:0] s_axis_tdata_1;
  logic              s_axis_tvalid_1;
  logic              s_axis_tready_1;
  logic [DWIDTH-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready;
  logic [1:0]        grant;

  modport master (
    input  en, burst_len,
    input  s_axis_tdata_0, s_axis_tvalid_0, s_axis_tdata_1, s_axis_tvalid_1,
    input  m_axis_tready,
    output s_axis_tready_0, s_axis_tready_1,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast, grant
  );

  modport slave (
    output en, burst_len,
    output s_axis_tdata_0, s_axis_tvalid_0, s_axis_tdata_1, s_axis_tvalid_1,
    output m_axis_tready,
    input  s_axis_tready_0, s_axis_tready_1,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, grant
  );
endinterface

// File: rtl/out_arbiter.sv
// Two-to-one AXI-Stream arbiter granting whole bursts round-robin, with one
// registered output stage carrying full ready/valid back-pressure.
module out_arbiter #(
  parameter int DWIDTH = 128,
  parameter int LEN_W  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  out_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_gnt_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_cnt_q;
  logic              load_len;

  logic [DWIDTH-1:0] data_p0;
  logic              vld_p0;
  logic              last_p0;

  logic              out_free;
  logic              rdy0, rdy1;
  logic              acc0, acc1, acc;
  logic              beat_last;
  logic              burst_end;
  logic              v0, v1;

  // A zero burst length still grants one beat.
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] l);
    return (l == '0) ? LEN_W'(1) : l;
  endfunction

  assign v0        = bus.s_axis_tvalid_0;
  assign v1        = bus.s_axis_tvalid_1;
  assign out_free  = ~vld_p0 | bus.m_axis_tready;
  assign rdy0      = (state_q == GNT0) & bus.en & out_free;
  assign rdy1      = (state_q == GNT1) & bus.en & out_free;
  assign acc0      = v0 & rdy0;
  assign acc1      = v1 & rdy1;
  assign acc       = acc0 | acc1;
  assign beat_last = (beat_cnt_q == len_q - LEN_W'(1));
  assign burst_end = acc & beat_last;

  always_comb begin
    state_d  = state_q;
    load_len = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.en && (v0 || v1)) begin
          load_len = 1'b1;
          if (v0 && v1)  state_d = last_gnt_q ? GNT0 : GNT1;
          else if (v0)   state_d = GNT0;
          else           state_d = GNT1;
        end
      end
      GNT0: begin
        if (burst_end) begin
          if (v1 && bus.en) begin
            state_d  = GNT1;
            load_len = 1'b1;
          end else if (v0 && bus.en) begin
            load_len = 1'b1;
          end else begin
            state_d  = IDLE;
          end
        end
      end
      GNT1: begin
        if (burst_end) begin
          if (v0 && bus.en) begin
            state_d  = GNT0;
            load_len = 1'b1;
          end else if (v1 && bus.en) begin
            load_len = 1'b1;
          end else begin
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      len_q      <= LEN_W'(1);
      beat_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_len) begin
        len_q      <= eff_len(bus.burst_len);
        beat_cnt_q <= '0;
      end else if (acc) begin
        beat_cnt_q <= beat_cnt_q + LEN_W'(1);
      end
      if (burst_end) last_gnt_q <= acc1;
    end
  end

  // ---- stage p0: registered output beat ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_p0 <= '0;
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
    end else if (acc) begin
      data_p0 <= acc1 ? bus.s_axis_tdata_1 : bus.s_axis_tdata_0;
      vld_p0  <= 1'b1;
      last_p0 <= beat_last;
    end else if (bus.m_axis_tready) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
    end
  end

  assign bus.s_axis_tready_0 = rdy0;
  assign bus.s_axis_tready_1 = rdy1;
  assign bus.m_axis_tdata    = data_p0;
  assign bus.m_axis_tvalid   = vld_p0;
  assign bus.m_axis_tlast    = last_p0;
  assign bus.grant           = {state_q == GNT1, state_q == GNT0};

endmodule
